lane_sbit_counter: RTL and testbench

- Producer side of the lane balance path: generates the per-lane set-bit counts that the lane balance comparator consumes.
- Accepts a frame of one or more beats, each carrying one DATA_WIDTH word per lane, over a valid/ready handshake.
- Accumulates a saturating popcount per lane across the frame.
- On the last beat, publishes a registered, stable count vector with a one-cycle valid pulse.

---
 rtl/vec_balance_pkg.sv | 22 ++
 rtl/lane_popcnt.sv | 12 +
 rtl/lane_sbit_counter.sv | 77 +++++++
 tb/tb_lane_sbit_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vec_balance_pkg.sv
// vec_balance_pkg: shared widths, types and the saturating accumulate used on the lane balance path.
package vec_balance_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int SBIT_CNT_B = $clog2(DATA_WIDTH);
  localparam int PC_W = SBIT_CNT_B + 1;
  typedef logic [SBIT_CNT_B-1:0] sbit_cnt_t;
  typedef logic [PC_W-1:0] pc_t;
  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} cnt_state_e;
  typedef struct packed {
    logic      hit;
    sbit_cnt_t val;
  } sat_res_t;
  // acc <= 2^B-1 and pc <= 2^B, so the sum fits in B+1 bits and its top bit alone flags overflow.
  function automatic sat_res_t sat_add(input sbit_cnt_t acc, input pc_t pc);
    pc_t      sum;
    sat_res_t res;
    sum = {1'b0, acc} + pc;
    res.hit = sum[SBIT_CNT_B];
    res.val = res.hit ? '1 : sum[SBIT_CNT_B-1:0];
    return res;
  endfunction
endpackage

// File: rtl/lane_popcnt.sv
// lane_popcnt: combinational set-bit count of one lane word.
module lane_popcnt #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic [$clog2(DATA_WIDTH):0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) cnt_o = cnt_o + ($clog2(DATA_WIDTH)+1)'(data_i[i]);
  end
endmodule

// File: rtl/lane_sbit_counter.sv
// lane_sbit_counter: per-lane saturating popcount over a frame of beats,
// published as a held count vector with a one-cycle valid pulse.
module lane_sbit_counter
  import vec_balance_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]     lane_data_i,
  input  logic                                 valid_i,
  input  logic                                 last_i,
  output logic                                 ready_o,
  input  logic                                 clear_i,
  output logic [LANES-1:0][SBIT_CNT_B-1:0]     lane_sbit_cnt_o,
  output logic                                 cnt_valid_o,
  output logic [LANES-1:0]                     sat_o
);
  cnt_state_e            r_state, w_next;
  logic                  r_ready;
  sbit_cnt_t [LANES-1:0] r_acc, w_val;
  logic [LANES-1:0]      r_acc_sat, w_hit;
  logic                  w_accept, w_pub;

  assign w_accept = valid_i & r_ready;
  assign w_pub = w_accept & last_i & ~clear_i;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pc_t      w_pc;
    sat_res_t w_res;
    lane_popcnt #(.DATA_WIDTH(DATA_WIDTH)) u_popcnt (.data_i(lane_data_i[l]), .cnt_o(w_pc));
    assign w_res = sat_add(r_acc[l], w_pc);
    assign w_val[l] = w_res.val;
    assign w_hit[l] = w_res.hit | r_acc_sat[l];
  end

  always_comb begin
    w_next = (clear_i || r_state == PUBLISH) ? IDLE :
             w_accept ? (last_i ? PUBLISH : ACCUM) : r_state;
  end

  // ready is registered from the next state so it stays low while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next != PUBLISH;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc           <= '0;
      r_acc_sat       <= '0;
      lane_sbit_cnt_o <= '0;
      sat_o           <= '0;
      cnt_valid_o     <= 1'b0;
    end else begin
      cnt_valid_o <= w_pub;
      if (clear_i || (w_accept && last_i)) begin
        r_acc     <= '0;
        r_acc_sat <= '0;
      end else if (w_accept) begin
        r_acc     <= w_val;
        r_acc_sat <= w_hit;
      end
      if (w_pub) begin
        lane_sbit_cnt_o <= w_val;
        sat_o           <= w_hit;
      end
    end
  end

  assign ready_o = r_ready;
endmodule

// File: tb/tb_lane_sbit_counter.sv
// tb_lane_sbit_counter: scoreboard bench; expected frames are queued on the last accepted beat.
module tb_lane_sbit_counter;
  localparam int L = 4;
  typedef logic [L-1:0][31:0] beat_t;
  typedef struct packed {
    logic [L-1:0][4:0] cnt;
    logic [L-1:0]      sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  beat_t             data = '0;
  logic              valid = 1'b0, last = 1'b0, clear = 1'b0;
  logic              ready, cnt_valid;
  logic [L-1:0][4:0] cnt;
  logic [L-1:0]      sat;

  exp_t        q[$];
  exp_t        last_pub = '0;
  int          checks = 0, errors = 0, pulses = 0, pushes = 0, p0 = 0;
  int unsigned acc_m[L];
  time         t_acc = 0, t_prev = 0;

  always #5 clk = ~clk;

  lane_sbit_counter #(.LANES(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .lane_data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready), .clear_i(clear), .lane_sbit_cnt_o(cnt), .cnt_valid_o(cnt_valid), .sat_o(sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < L; l++) acc_m[l] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input beat_t d, input logic lst);
    exp_t e;
    int   n;
    data = d; valid = 1'b1; last = lst;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 20);
    check("ready_wait", ready, 1);
    @(posedge clk);
    t_prev = t_acc;
    t_acc = $time;
    for (int l = 0; l < L; l++) acc_m[l] += $countones(d[l]);
    if (lst) begin
      for (int l = 0; l < L; l++) begin
        e.cnt[l] = acc_m[l] > 31 ? 5'd31 : 5'(acc_m[l]);
        e.sat[l] = acc_m[l] > 31;
      end
      q.push_back(e);
      pushes++;
      model_clear();
    end
    #1 valid = 1'b0; last = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && cnt_valid) begin
      pulses++;
      check("ready_in_publish", ready, 0);
      check("queue_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        last_pub = q.pop_front();
        check("pub_cnt", cnt, last_pub.cnt);
        check("pub_sat", sat, last_pub.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    #1;
    check("rst_ready", ready, 0);
    check("rst_valid", cnt_valid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_sat", sat, 0);
    #11 rst_n = 1'b1;
    idle(2);
    check("ready_after_rst", ready, 1);
    // single-beat frame
    send({32'h80000001, 32'h0, 32'hFF, 32'hF}, 1'b1);
    check("pulse_t1", cnt_valid, 1);
    check("ready_t1", ready, 0);
    check("cnt_t1", cnt, {5'd2, 5'd0, 5'd8, 5'd4});
    idle(1);
    check("pulse_gone", cnt_valid, 0);
    check("ready_back", ready, 1);
    idle(1);
    check("pulses_single", pulses, 1);
    // three-beat frame
    p0 = pulses;
    send({96'h0, 32'h3}, 1'b0);
    idle(2);
    check("no_pub_beat1", pulses, p0);
    send({96'h0, 32'h3}, 1'b0);
    idle(2);
    check("no_pub_beat2", pulses, p0);
    check("hold_cnt", cnt, {5'd2, 5'd0, 5'd8, 5'd4});
    send({96'h0, 32'h3}, 1'b1);
    idle(2);
    check("pub_three", pulses, p0 + 1);
    // saturation then recovery
    send({96'h0, 32'hFFFFFFFF}, 1'b1);
    idle(2);
    check("sat_lane0", sat, 4'b0001);
    send({96'h0, 32'h1}, 1'b1);
    idle(2);
    check("unsat_lane0", sat, 4'b0000);
    send({64'h0, 32'h0000FFFF, 32'h0}, 1'b0);
    send({64'h0, 32'h0000FFFF, 32'h0}, 1'b0);
    send({64'h0, 32'hFFFFFFFF, 32'h0}, 1'b0);
    send({64'h0, 32'h0000000F, 32'h0}, 1'b1);
    idle(2);
    check("sat_multi", cnt[1], 31);
    // back-to-back frames with valid held across the publish cycle
    send({32'h1, 32'h3, 32'h7, 32'hF}, 1'b1);
    send({32'hF0, 32'h70, 32'h30, 32'h10}, 1'b1);
    check("b2b_gap", 32'(t_acc - t_prev), 20);
    send({32'h0, 32'h0, 32'h0, 32'h1}, 1'b0);
    send({32'h0, 32'h0, 32'h0, 32'h1}, 1'b1);
    idle(2);
    // clear after two non-last beats
    p0 = pulses;
    send({32'hFF, 32'h0, 32'h0, 32'hFF}, 1'b0);
    send({32'hFF, 32'h0, 32'h0, 32'hFF}, 1'b0);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    model_clear();
    idle(2);
    check("clear_no_pub", pulses, p0);
    check("clear_hold_cnt", cnt, last_pub.cnt);
    check("clear_hold_sat", sat, last_pub.sat);
    send({32'h0, 32'h7, 32'h0, 32'h0}, 1'b1);
    idle(2);
    check("after_clear", cnt, {5'd0, 5'd3, 5'd0, 5'd0});
    // clear together with an accepted last beat
    p0 = pulses;
    send({96'h0, 32'hF}, 1'b0);
    data = {96'h0, 32'hFF}; valid = 1'b1; last = 1'b1; clear = 1'b1;
    @(negedge clk);
    check("ready_clr_last", ready, 1);
    idle(1);
    valid = 1'b0; last = 1'b0; clear = 1'b0;
    model_clear();
    idle(3);
    check("clr_last_no_pub", pulses, p0);
    check("clr_last_ready", ready, 1);
    send({96'h0, 32'h1}, 1'b1);
    idle(2);
    check("after_clr_last", cnt, {5'd0, 5'd0, 5'd0, 5'd1});
    // asynchronous reset mid-frame
    send({96'h0, 32'hFF}, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", cnt, 0);
    check("arst_sat", sat, 0);
    check("arst_valid", cnt_valid, 0);
    check("arst_ready", ready, 0);
    model_clear();
    last_pub = '0;
    #4 rst_n = 1'b1;
    idle(3);
    send({32'h3, 96'h0}, 1'b1);
    idle(2);
    check("after_arst", cnt, {5'd2, 5'd0, 5'd0, 5'd0});
    idle(3);
    check("queue_empty", q.size(), 0);
    check("pulse_total", pulses, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
